// File: rtl/jahangir_pkg.sv
// Shared definitions for the Jahangir MIPS32 pipeline: datapath width,
// reset defaults and the instruction-fetch FSM encoding.
package jahangir_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0000;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_KILL  = 2'd1,
      ST_FULL  = 2'd2
   } fetch_state_e;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & {{(XLEN-2){1'b1}}, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry {pc, inst} holding buffer that absorbs the word returned while
// decode is stalled. Flush wins over load, load wins over unload.
module fetch_skid
   import jahangir_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            load_i,
   input  logic            unload_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] inst_i,
   output logic            valid_o,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] inst_o
);

   logic            valid_q, valid_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] inst_q, inst_d;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         pc_d    = pc_i;
         inst_d  = inst_i;
      end else if (unload_i) begin
         valid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         inst_q  <= INST_NOP;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
      end
   end

   assign valid_o = valid_q;
   assign pc_o    = pc_q;
   assign inst_o  = inst_q;

endmodule

// File: rtl/if_fetch.sv
// MIPS32 instruction-fetch stage: owns the PC, runs the imem req/ack
// handshake and presents {pc, inst, valid} to the IF/ID register.
module if_fetch
   import jahangir_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_i,
   input  logic            br_taken_i,
   input  logic [XLEN-1:0] br_target_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_ack_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic [XLEN-1:0] if_pc_o,
   output logic [XLEN-1:0] if_inst_o,
   output logic            if_valid_o
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] kill_addr_q, kill_addr_d;
   logic [XLEN-1:0] out_pc_q, out_pc_d;
   logic [XLEN-1:0] out_inst_q, out_inst_d;
   logic            out_valid_q, out_valid_d;
   logic            run_q;
   logic            ack_v, consume;
   logic            skid_load, skid_unload, skid_flush, skid_valid;
   logic [XLEN-1:0] skid_pc, skid_inst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_FETCH;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (br_taken_i) begin
         unique case (state_q)
            ST_FETCH: state_d = (imem_req_o && !ack_v) ? ST_KILL : ST_FETCH;
            ST_KILL:  state_d = ack_v ? ST_FETCH : ST_KILL;
            default:  state_d = ST_FETCH;
         endcase
      end else begin
         unique case (state_q)
            ST_FETCH: if (ack_v && !consume) state_d = ST_FULL;
            ST_KILL:  if (ack_v) state_d = ST_FETCH;
            ST_FULL:  if (!stall_i) state_d = ST_FETCH;
            default:  state_d = ST_FETCH;
         endcase
      end
   end

   // The request is held off for the first cycle so nothing is issued while rst is high.
   always_comb begin
      imem_req_o  = run_q && (state_q != ST_FULL);
      imem_addr_o = (state_q == ST_KILL) ? kill_addr_q : pc_q;
      ack_v       = imem_ack_i && imem_req_o;
      consume     = !out_valid_q || !stall_i;
   end

   always_comb begin
      pc_d        = pc_q;
      kill_addr_d = kill_addr_q;
      out_pc_d    = out_pc_q;
      out_inst_d  = out_inst_q;
      out_valid_d = out_valid_q;
      skid_load   = 1'b0;
      skid_unload = 1'b0;
      skid_flush  = 1'b0;
      if (br_taken_i) begin
         pc_d        = word_align(br_target_i);
         out_valid_d = 1'b0;
         skid_flush  = 1'b1;
         if (state_q == ST_FETCH) kill_addr_d = pc_q;
      end else begin
         unique case (state_q)
            ST_FETCH: begin
               if (ack_v) begin
                  pc_d = pc_q + XLEN'(4);
                  if (consume) begin
                     out_pc_d    = pc_q;
                     out_inst_d  = imem_rdata_i;
                     out_valid_d = 1'b1;
                  end else begin
                     skid_load = 1'b1;
                  end
               end else if (!stall_i) begin
                  out_valid_d = 1'b0;
               end
            end
            ST_FULL: begin
               if (!stall_i) begin
                  out_pc_d    = skid_pc;
                  out_inst_d  = skid_inst;
                  out_valid_d = skid_valid;
                  skid_unload = 1'b1;
               end
            end
            default: begin
               if (!stall_i) out_valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_q       <= 1'b0;
         pc_q        <= RESET_PC;
         kill_addr_q <= RESET_PC;
         out_pc_q    <= '0;
         out_inst_q  <= INST_NOP;
         out_valid_q <= 1'b0;
      end else begin
         run_q       <= 1'b1;
         pc_q        <= pc_d;
         kill_addr_q <= kill_addr_d;
         out_pc_q    <= out_pc_d;
         out_inst_q  <= out_inst_d;
         out_valid_q <= out_valid_d;
      end
   end

   fetch_skid u_skid (
      .clk      (clk),
      .rst      (rst),
      .load_i   (skid_load),
      .unload_i (skid_unload),
      .flush_i  (skid_flush),
      .pc_i     (pc_q),
      .inst_i   (imem_rdata_i),
      .valid_o  (skid_valid),
      .pc_o     (skid_pc),
      .inst_o   (skid_inst)
   );

   assign if_pc_o    = out_pc_q;
   assign if_inst_o  = out_inst_q;
   assign if_valid_o = out_valid_q;

endmodule
